// File: rtl/servo_pkg.sv
// Shared defaults, FSM state encoding and frame-length helper for the servo tracking controller.
package servo_pkg;

  localparam int unsigned DEF_CLK_FREQUENCY = 50_000_000;
  localparam int unsigned DEF_POS_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_PARK  = 2'b10
  } servo_state_e;

  function automatic int unsigned frame_cycles(input int unsigned freq, input int unsigned us);
    return (freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/servo_comp_sync.sv
// Two-flop synchronizer for one asynchronous comparator input.
// Defining SERVO_TRACK_FILTER_EN adds a FILTER_CYCLES stability filter after the synchronizer.
module servo_comp_sync
`ifdef SERVO_TRACK_FILTER_EN
  #(parameter int unsigned FILTER_CYCLES = 1000)
`endif
  (
  input  logic clk_i,
  input  logic reset_i,
  input  logic comp_async_i,
  output logic comp_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= comp_async_i;
      sync_q <= meta_q;
    end
  end

`ifdef SERVO_TRACK_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] RUN_LAST = FW'(FILTER_CYCLES - 1);

  logic          filt_q;
  logic          filt_d;
  logic [FW-1:0] run_q;
  logic [FW-1:0] run_d;

  // Count consecutive cycles the synchronized value disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync_q != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = sync_q;
      end else begin
        run_d = run_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign comp_o = filt_q;
`else
  assign comp_o = sync_q;
`endif

endmodule

// File: rtl/servo_track_ctrl.sv
// XY servo tracking controller: one axis update per frame tick with IDLE/TRACK/PARK sequencing.
// Define SERVO_TRACK_FILTER_EN to insert a comparator stability filter of FILTER_CYCLES cycles.
module servo_track_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = DEF_CLK_FREQUENCY,
  parameter int unsigned FRAME_US      = 20000,
  parameter int unsigned POS_W         = DEF_POS_W,
  parameter int unsigned POS_MIN       = 0,
  parameter int unsigned POS_MAX       = 255,
  parameter int unsigned POS_CENTER    = 128,
  parameter int unsigned STEP          = 1,
  parameter int unsigned LOST_FRAMES   = 25
`ifdef SERVO_TRACK_FILTER_EN
  ,
  parameter int unsigned FILTER_CYCLES = 1000
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             comp_async_x_i,
  input  logic             comp_async_y_i,
  output logic [POS_W-1:0] pos_x_o,
  output logic [POS_W-1:0] pos_y_o,
  output logic             pos_valid_o,
  output logic             frame_tick_o,
  output logic [1:0]       state_o
);

  localparam int unsigned FRAME_CYCLES = frame_cycles(CLK_FREQUENCY, FRAME_US);
  localparam int unsigned CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_FRAMES - 1);
  localparam logic [POS_W-1:0]  P_MIN     = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  P_MAX     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  P_CTR     = POS_W'(POS_CENTER);
  localparam logic [POS_W-1:0]  P_STEP    = POS_W'(STEP);
  localparam logic [POS_W-1:0]  P_UP_LIM  = POS_W'(POS_MAX - STEP);
  localparam logic [POS_W-1:0]  P_DN_LIM  = POS_W'(POS_MIN + STEP);

  logic comp_x;
  logic comp_y;

`ifdef SERVO_TRACK_FILTER_EN
  servo_comp_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_x (
`else
  servo_comp_sync u_sync_x (
`endif
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .comp_async_i (comp_async_x_i),
    .comp_o       (comp_x)
  );

`ifdef SERVO_TRACK_FILTER_EN
  servo_comp_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_y (
`else
  servo_comp_sync u_sync_y (
`endif
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .comp_async_i (comp_async_y_i),
    .comp_o       (comp_y)
  );

  // Limits are compared before the add/subtract so the position never wraps.
  function automatic logic [POS_W-1:0] track_step(input logic [POS_W-1:0] pos, input logic up);
    if (up) return (pos >= P_UP_LIM) ? P_MAX : pos + P_STEP;
    return (pos <= P_DN_LIM) ? P_MIN : pos - P_STEP;
  endfunction

  function automatic logic [POS_W-1:0] park_step(input logic [POS_W-1:0] pos);
    if (pos >= P_CTR) return ((pos - P_CTR) <= P_STEP) ? P_CTR : pos - P_STEP;
    return ((P_CTR - pos) <= P_STEP) ? P_CTR : pos + P_STEP;
  endfunction

  function automatic logic pinned(input logic [POS_W-1:0] pos);
    return (pos == P_MIN) || (pos == P_MAX);
  endfunction

  servo_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              valid_q;
  logic              axis_y_q, axis_y_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic [POS_W-1:0]  pos_x_q, pos_x_d;
  logic [POS_W-1:0]  pos_y_q, pos_y_d;
  logic [POS_W-1:0]  nx, ny;

  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d   = (cnt_d == CNT_LAST);
    state_d  = state_q;
    axis_y_d = axis_y_q;
    lost_d   = lost_q;
    nx       = pos_x_q;
    ny       = pos_y_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          lost_d = '0;
          if (enable_i) begin
            state_d  = ST_TRACK;
            axis_y_d = 1'b0;
          end
        end
        ST_TRACK: begin
          if (!enable_i) begin
            state_d = ST_PARK;
            lost_d  = '0;
          end else begin
            if (axis_y_q) ny = track_step(pos_y_q, comp_y);
            else          nx = track_step(pos_x_q, comp_x);
            axis_y_d = !axis_y_q;
            if (pinned(nx) && pinned(ny)) begin
              if (lost_q == LOST_LAST) begin
                state_d = ST_PARK;
                lost_d  = '0;
              end else begin
                lost_d = lost_q + LOST_W'(1);
              end
            end else begin
              lost_d = '0;
            end
          end
        end
        ST_PARK: begin
          nx = park_step(pos_x_q);
          ny = park_step(pos_y_q);
          if ((nx == P_CTR) && (ny == P_CTR)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    pos_x_d = nx;
    pos_y_d = ny;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      axis_y_q <= 1'b0;
      lost_q   <= '0;
      pos_x_q  <= P_CTR;
      pos_y_q  <= P_CTR;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      valid_q  <= tick_q;
      axis_y_q <= axis_y_d;
      lost_q   <= lost_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign pos_valid_o  = valid_q;
  assign frame_tick_o = tick_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_servo_track_ctrl.sv
// Self-checking bench for servo_track_ctrl: vector table, directed pin/park and reset sequences,
// and randomized frames checked against an arithmetic reference model.
module tb_servo_track_ctrl;

  localparam int CLKF = 1_000_000;
  localparam int FUS  = 10;
  localparam int STEP = 4;
  localparam int LOST = 3;
  localparam int PMIN = 0;
  localparam int PMAX = 255;
  localparam int CTR  = 128;
  localparam int SMAX = 130;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cx = 1'b0, cy = 1'b0;
  logic scx = 1'b1, scy = 1'b0;
  logic [7:0] px, py, spx, spy;
  logic pv, ft, spv, sft;
  logic [1:0] st, sst;

  int n_cmp = 0;
  int n_bad = 0;

  int mx, my, mst, mlost;
  bit maxy;

  servo_track_ctrl #(
    .CLK_FREQUENCY(CLKF), .FRAME_US(FUS), .POS_W(8), .POS_MIN(PMIN), .POS_MAX(PMAX),
    .POS_CENTER(CTR), .STEP(STEP), .LOST_FRAMES(LOST)
`ifdef SERVO_TRACK_FILTER_EN
    , .FILTER_CYCLES(5)
`endif
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .comp_async_x_i(cx), .comp_async_y_i(cy),
    .pos_x_o(px), .pos_y_o(py), .pos_valid_o(pv), .frame_tick_o(ft), .state_o(st)
  );

  // Second instance with a non-power-of-two upper limit.
  servo_track_ctrl #(
    .CLK_FREQUENCY(CLKF), .FRAME_US(FUS), .POS_W(8), .POS_MIN(PMIN), .POS_MAX(SMAX),
    .POS_CENTER(CTR), .STEP(STEP), .LOST_FRAMES(LOST)
`ifdef SERVO_TRACK_FILTER_EN
    , .FILTER_CYCLES(5)
`endif
  ) dut_s (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .comp_async_x_i(scx), .comp_async_y_i(scy),
    .pos_x_o(spx), .pos_y_o(spy), .pos_valid_o(spv), .frame_tick_o(sft), .state_o(sst)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int move(input int p, input bit up);
    if (up) return (p + STEP > PMAX) ? PMAX : p + STEP;
    return (p - STEP < PMIN) ? PMIN : p - STEP;
  endfunction

  function automatic int home(input int p);
    int d;
    d = p - CTR;
    if (d <= STEP && d >= -STEP) return CTR;
    return (d > 0) ? p - STEP : p + STEP;
  endfunction

  function automatic bit at_limit(input int p);
    return (p == PMIN) || (p == PMAX);
  endfunction

  task automatic model_reset();
    mx = CTR; my = CTR; mst = 0; mlost = 0; maxy = 1'b0;
  endtask

  task automatic model_tick(input bit en, input bit ix, input bit iy);
    case (mst)
      0: if (en) begin mst = 1; maxy = 1'b0; end
      1: begin
        if (!en) begin
          mst = 2; mlost = 0;
        end else begin
          if (maxy) my = move(my, iy);
          else      mx = move(mx, ix);
          maxy = !maxy;
          if (at_limit(mx) && at_limit(my)) begin
            mlost++;
            if (mlost == LOST) begin mst = 2; mlost = 0; end
          end else begin
            mlost = 0;
          end
        end
      end
      default: begin
        mx = home(mx); my = home(my);
        if (mx == CTR && my == CTR) mst = 0;
      end
    endcase
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ft !== 1'b1 && n < 40);
    if (ft !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no frame tick within %0d cycles", n);
    end
  endtask

  // Drive one frame's inputs (optionally preceded by a one-cycle opposite glitch), step the model
  // at the tick and return at the negedge of the cycle where pos_valid should be high.
  task automatic do_frame(input bit en, input bit ix, input bit iy, input bit glitch, output bit ok);
    int n;
    if (glitch) begin
      enable = ~en; cx = ~ix; cy = ~iy;
      @(negedge clk);
    end
    enable = en; cx = ix; cy = iy;
    wait_tick(n);
    ok = (ft === 1'b1);
    if (ok) begin
      model_tick(en, ix, iy);
      @(negedge clk);
    end
  endtask

  task automatic chk_model();
    chk("valid", int'(pv), 1);
    chk("pos_x", int'(px), mx);
    chk("pos_y", int'(py), my);
    chk("state", int'(st), mst);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit en; bit ix; bit iy;
    int ex; int ey; int est;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int   n;
    bit   ok;
    bit   seen_park;
    int   prev;

    tbl[0]  = '{1, 1, 0, 128, 128, 1};
    tbl[1]  = '{1, 1, 0, 132, 128, 1};
    tbl[2]  = '{1, 1, 0, 132, 124, 1};
    tbl[3]  = '{1, 1, 0, 136, 124, 1};
    tbl[4]  = '{1, 1, 0, 136, 120, 1};
    tbl[5]  = '{0, 1, 0, 136, 120, 2};
    tbl[6]  = '{1, 1, 0, 132, 124, 2};
    tbl[7]  = '{1, 0, 1, 128, 128, 0};
    tbl[8]  = '{0, 0, 1, 128, 128, 0};
    tbl[9]  = '{1, 0, 1, 128, 128, 1};
    tbl[10] = '{1, 0, 1, 124, 128, 1};
    tbl[11] = '{1, 0, 1, 124, 132, 1};

    model_reset();

    // Reset values, tick spacing and valid strobe timing with tracking disabled.
    repeat (3) @(negedge clk);
    chk("rst_x", int'(px), CTR);
    chk("rst_y", int'(py), CTR);
    chk("rst_state", int'(st), 0);
    chk("rst_valid", int'(pv), 0);
    chk("rst_tick", int'(ft), 0);
    reset = 1'b0;
    wait_tick(n);
    chk("first_tick_latency", n, 9);
    @(negedge clk);
    chk("valid_after_tick", int'(pv), 1);
    chk("tick_one_cycle", int'(ft), 0);
    wait_tick(n);
    chk("tick_period", n + 1, 10);
    chk("valid_low_on_tick", int'(pv), 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      do_frame(1'b0, 1'b1, 1'b0, 1'b0, ok);
      if (ok) chk_model();
    end

    // Vector table: alternating axis updates, PARK via enable drop, re-entry to TRACK.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_frame(tbl[i].en, tbl[i].ix, tbl[i].iy, 1'b0, ok);
      if (ok) begin
        chk($sformatf("vec%0d_valid", i), int'(pv), 1);
        chk($sformatf("vec%0d_x", i), int'(px), tbl[i].ex);
        chk($sformatf("vec%0d_y", i), int'(py), tbl[i].ey);
        chk($sformatf("vec%0d_state", i), int'(st), tbl[i].est);
        if (i <= 4) chk($sformatf("sat130_x%0d", i), int'(spx), (i == 0) ? CTR : SMAX);
      end
    end

    // Drive both axes into their limits until the lost counter parks, then home to IDLE.
    do_reset();
    seen_park = 1'b0;
    for (int k = 0; k < 200 && !(seen_park && mst == 0); k++) begin
      prev = mst;
      do_frame(1'b1, 1'b1, 1'b0, 1'b0, ok);
      if (ok) begin
        chk_model();
        if (prev == 1 && mst == 2 && !seen_park) begin
          seen_park = 1'b1;
          chk("park_entry_x", int'(px), PMAX);
          chk("park_entry_y", int'(py), PMIN);
          chk("park_entry_frame", k, 66);
        end
      end
    end
    chk("park_seen", int'(seen_park), 1);
    chk("idle_after_park", int'(st), 0);

    // Randomized frames with glitches between ticks.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      do_frame(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'($urandom), ok);
      if (ok) chk_model();
    end

    // Asynchronous reset in the middle of TRACK, then frame counter restart.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_frame(1'b1, 1'b1, 1'b1, 1'b0, ok);
      if (ok) chk_model();
    end
    chk("pre_reset_x", int'(px), 132);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_x", int'(px), CTR);
    chk("async_rst_y", int'(py), CTR);
    chk("async_rst_state", int'(st), 0);
    chk("async_rst_valid", int'(pv), 0);
    chk("async_rst_tick", int'(ft), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    enable = 1'b0;
    wait_tick(n);
    chk("restart_latency", n, 9);
    @(negedge clk);
    chk("restart_state", int'(st), 0);
    chk("restart_x", int'(px), CTR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
